// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

  // Controller states; the unused encoding 2'd3 falls back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Booth op-codes, indexed by {Q[0], q_m1}.
  // 2'b11 is also a no-op and is handled by the step logic.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Ceiling log2 with a floor of 1, so a counter is never zero bits wide.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration.
// It does a conditional add/subtract of M into A, then an arithmetic right
// shift of the combined value {A, Q, q_m1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int W = 9
) (
  input  logic signed [W-1:0] a_i,
  input  logic        [W-1:0] q_i,
  input  logic                q_m1_i,
  input  logic signed [W-1:0] m_i,
  output logic signed [W-1:0] next_a,
  output logic        [W-1:0] next_q,
  output logic                next_q_m1
);

  logic [1:0]          op;
  logic                sub;
  logic                do_arith;
  logic signed [W-1:0] addend;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] res;

  // A single adder serves both operations: subtract is add of ~M with carry-in.
  always_comb begin
    op        = {q_i[0], q_m1_i};
    sub       = (op == BOOTH_SUB);
    do_arith  = (op == BOOTH_ADD) || (op == BOOTH_SUB);
    addend    = sub ? ~m_i : m_i;
    sum       = a_i + addend + W'(sub);
    res       = do_arith ? sum : a_i;
    next_a    = {res[W-1], res[W-1:1]};
    next_q    = {res[0], q_i[W-1:1]};
    next_q_m1 = q_i[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier with valid/ready operand and product
// handshakes.
// Operands are extended by one bit, so the signed Booth core also covers
// unsigned operands and the most-negative multiplicand.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = clog2(W1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W1 - 1);

  state_e               state_q, state_d;
  logic signed [W1-1:0] a_q, a_d;
  logic        [W1-1:0] q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic signed [W1-1:0] m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic signed [W1-1:0] step_a;
  logic        [W1-1:0] step_q;
  logic                 step_qm1;

  booth_step #(.W(W1)) u_step (
    .a_i       (a_q),
    .q_i       (q_q),
    .q_m1_i    (qm1_q),
    .m_i       (m_q),
    .next_a    (step_a),
    .next_q    (step_q),
    .next_q_m1 (step_qm1)
  );

  // Next-state and datapath update; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = '0;
          q_d     = is_signed ? {mplier[WIDTH-1], mplier} : {1'b0, mplier};
          qm1_d   = 1'b0;
          m_d     = is_signed ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        a_d   = step_a;
        q_d   = step_q;
        qm1_d = step_qm1;
        if (cnt_q == CNT_LAST) begin
          // The low 2*WIDTH bits of {A, Q} are A[WIDTH-2:0] followed by all of Q.
          product_d = {step_a[WIDTH-2:0], step_q};
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      a_d       = a_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      cnt_d     = '0;
      product_d = product_q;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake and status outputs are decoded directly from the state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_BUSY);
    product   = product_q;
  end

endmodule
